// File: rtl/memory_arbiter_if.sv
// Cache/RAM side bundle of the memory arbiter.
// master = arbiter view, slave = caches + RAM view.
interface memory_arbiter_if #(
    parameter int WORD_W = 32
);
    logic              iREN;
    logic [WORD_W-1:0] iaddr;
    logic              iwait;
    logic [WORD_W-1:0] iload;
    logic              dREN;
    logic              dWEN;
    logic [WORD_W-1:0] daddr;
    logic [WORD_W-1:0] dstore;
    logic              dwait;
    logic [WORD_W-1:0] dload;
    logic              ramREN;
    logic              ramWEN;
    logic [WORD_W-1:0] ramaddr;
    logic [WORD_W-1:0] ramstore;
    logic [WORD_W-1:0] ramload;
    logic [1:0]        ramstate;
    logic              arb_err;

    modport master (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, arb_err
    );

    modport slave (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, arb_err
    );
endinterface

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter between icache and dcache; dcache wins by default.
// ARB_FAIRNESS_EN: force an icache grant after STARVE_LIMIT dcache grants while icache waits.
module memory_arbiter #(
    parameter int WORD_W = 32
`ifdef ARB_FAIRNESS_EN
   ,parameter int STARVE_LIMIT = 4
`endif
) (
    input  logic              CLK,
    input  logic              nRST,
    memory_arbiter_if.master  bus
);
    typedef enum logic [1:0] {IDLE, IGNT, DGNT} state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    state_t            state, next_state;
    logic              arb_err_q;
    logic              dreq;
    logic              grant_err;
    logic              starve_hit;
    logic              ren_c, wen_c, iwait_c, dwait_c;
    logic [WORD_W-1:0] addr_mux, store_mux;

    assign dreq      = bus.dREN | bus.dWEN;
    assign grant_err = (state != IDLE) && (bus.ramstate == RAM_ERROR);

`ifdef ARB_FAIRNESS_EN
    logic [2:0] starve_cnt;
    logic       d_done;

    assign d_done     = (state == DGNT) && dreq && (bus.ramstate == RAM_ACCESS);
    assign starve_hit = bus.iREN && (int'(starve_cnt) >= STARVE_LIMIT);

    // Counts dcache completions the icache had to sit through; saturates.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            starve_cnt <= 3'd0;
        else if (!bus.iREN || state == IGNT)
            starve_cnt <= 3'd0;
        else if (d_done && starve_cnt != 3'd7)
            starve_cnt <= starve_cnt + 3'd1;
    end
`else
    assign starve_hit = 1'b0;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            arb_err_q <= 1'b0;
        end else begin
            state <= next_state;
            if (grant_err)
                arb_err_q <= 1'b1;
        end
    end

    // Every grant returns to IDLE, so back-to-back transactions see one bubble.
    always_comb begin
        next_state = state;
        ren_c      = 1'b0;
        wen_c      = 1'b0;
        iwait_c    = 1'b1;
        dwait_c    = 1'b1;
        addr_mux   = '0;
        store_mux  = '0;
        case (state)
            IDLE: begin
                if (starve_hit)
                    next_state = IGNT;
                else if (dreq)
                    next_state = DGNT;
                else if (bus.iREN)
                    next_state = IGNT;
            end
            IGNT: begin
                ren_c    = bus.iREN;
                addr_mux = bus.iaddr;
                if (!bus.iREN)
                    next_state = IDLE;
                else if (bus.ramstate == RAM_ACCESS) begin
                    iwait_c    = 1'b0;
                    next_state = IDLE;
                end else if (bus.ramstate == RAM_ERROR)
                    next_state = IDLE;
            end
            DGNT: begin
                wen_c     = bus.dWEN;
                ren_c     = bus.dREN & ~bus.dWEN;
                addr_mux  = bus.daddr;
                store_mux = bus.dstore;
                if (!dreq)
                    next_state = IDLE;
                else if (bus.ramstate == RAM_ACCESS) begin
                    dwait_c    = 1'b0;
                    next_state = IDLE;
                end else if (bus.ramstate == RAM_ERROR)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign bus.ramREN   = ren_c;
    assign bus.ramWEN   = wen_c;
    assign bus.ramaddr  = addr_mux;
    assign bus.ramstore = store_mux;
    assign bus.iwait    = iwait_c;
    assign bus.dwait    = dwait_c;
    assign bus.iload    = bus.ramload;
    assign bus.dload    = bus.ramload;
    assign bus.arb_err  = arb_err_q;
endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: transaction-level owner model checked every cycle
// plus hand-computed expectations for each scenario.
module tb_memory_arbiter;
`ifdef ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif
    localparam int LIMIT = 4;
    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    int checks = 0;
    int failures = 0;

    memory_arbiter_if #(.WORD_W(32)) bus ();
    memory_arbiter #(.WORD_W(32)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: who currently owns the RAM (0 nobody, 1 icache, 2 dcache).
    int owner = 0;
    int dstreak = 0;
    bit err_m = 1'b0;

    always @(posedge CLK or negedge nRST) begin
        int  nxt;
        bit  dr, req;
        if (!nRST) begin
            owner = 0; dstreak = 0; err_m = 1'b0;
        end else begin
            dr  = bus.dREN | bus.dWEN;
            nxt = owner;
            if (owner == 0) begin
                if (FAIR && bus.iREN && dstreak >= LIMIT) nxt = 1;
                else if (dr) nxt = 2;
                else if (bus.iREN) nxt = 1;
            end else begin
                req = (owner == 1) ? bus.iREN : dr;
                if (bus.ramstate == ERROR) err_m = 1'b1;
                if (!req || bus.ramstate == ACCESS || bus.ramstate == ERROR) nxt = 0;
            end
            if (!bus.iREN || owner == 1) dstreak = 0;
            else if (owner == 2 && dr && bus.ramstate == ACCESS && dstreak < 7) dstreak++;
            owner = nxt;
        end
    end

    always @(negedge CLK) begin
        bit dr, hit;
        if (nRST) begin
            dr  = bus.dREN | bus.dWEN;
            hit = bus.ramstate == ACCESS;
            chk("m_iwait", bus.iwait, !(owner == 1 && bus.iREN && hit));
            chk("m_dwait", bus.dwait, !(owner == 2 && dr && hit));
            chk("m_ramREN", bus.ramREN,
                owner == 1 ? bus.iREN : (owner == 2 ? (bus.dREN && !bus.dWEN) : 1'b0));
            chk("m_ramWEN", bus.ramWEN, owner == 2 && bus.dWEN);
            chk("m_ramaddr", bus.ramaddr,
                owner == 1 ? bus.iaddr : (owner == 2 ? bus.daddr : 32'h0));
            chk("m_ramstore", bus.ramstore, owner == 2 ? bus.dstore : 32'h0);
            chk("m_iload", bus.iload, bus.ramload);
            chk("m_dload", bus.dload, bus.ramload);
            chk("m_arb_err", bus.arb_err, err_m);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int seq[$];
        int ntr, igr;
        bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0;
        bus.daddr = 0; bus.dstore = 0; bus.ramload = 32'hA5A5_0001; bus.ramstate = FREE;
        #1;
        chk("rst_iwait", bus.iwait, 1); chk("rst_dwait", bus.dwait, 1);
        chk("rst_ramREN", bus.ramREN, 0); chk("rst_ramWEN", bus.ramWEN, 0);
        chk("rst_ramaddr", bus.ramaddr, 0); chk("rst_ramstore", bus.ramstore, 0);
        chk("rst_arb_err", bus.arb_err, 0); chk("rst_iload", bus.iload, 32'hA5A5_0001);
        chk("rst_dload", bus.dload, 32'hA5A5_0001);
        tick(); tick(); nRST = 1;

        // icache read, RAM answers immediately
        tick();
        bus.iREN = 1; bus.iaddr = 32'h40; bus.ramload = 32'hDEADBEEF; bus.ramstate = ACCESS;
        @(negedge CLK); chk("t2_req_iwait", bus.iwait, 1); chk("t2_req_ren", bus.ramREN, 0);
        tick();
        @(negedge CLK);
        chk("t2_ren", bus.ramREN, 1); chk("t2_addr", bus.ramaddr, 32'h40);
        chk("t2_iwait", bus.iwait, 0); chk("t2_iload", bus.iload, 32'hDEADBEEF);
        tick(); bus.iREN = 0;
        @(negedge CLK); chk("t2_after_iwait", bus.iwait, 1); chk("t2_after_ren", bus.ramREN, 0);

        // simultaneous requests: dcache first, one bubble, then icache
        tick();
        bus.iREN = 1; bus.iaddr = 32'h44; bus.dWEN = 1; bus.daddr = 32'h80; bus.dstore = 32'h1234;
        tick();
        @(negedge CLK);
        chk("t3_wen", bus.ramWEN, 1); chk("t3_store", bus.ramstore, 32'h1234);
        chk("t3_daddr", bus.ramaddr, 32'h80); chk("t3_dwait", bus.dwait, 0);
        chk("t3_iwait_d", bus.iwait, 1); chk("t3_ren_d", bus.ramREN, 0);
        tick(); bus.dWEN = 0;
        @(negedge CLK); chk("t3_bub_wen", bus.ramWEN, 0); chk("t3_bub_ren", bus.ramREN, 0);
        chk("t3_bub_iwait", bus.iwait, 1);
        tick();
        @(negedge CLK); chk("t3_i_ren", bus.ramREN, 1); chk("t3_i_addr", bus.ramaddr, 32'h44);
        chk("t3_i_iwait", bus.iwait, 0);
        tick(); bus.iREN = 0;

        // dcache read with three BUSY cycles
        bus.dREN = 1; bus.daddr = 32'h100; bus.ramstate = BUSY; bus.ramload = 32'h0BAD_F00D;
        for (int k = 0; k < 3; k++) begin
            tick();
            @(negedge CLK); chk("t4_busy_dwait", bus.dwait, 1); chk("t4_busy_ren", bus.ramREN, 1);
        end
        tick(); bus.ramstate = ACCESS;
        @(negedge CLK); chk("t4_dwait", bus.dwait, 0); chk("t4_dload", bus.dload, 32'h0BAD_F00D);
        tick(); bus.dREN = 0;
        @(negedge CLK); chk("t4_idle_dwait", bus.dwait, 1); chk("t4_idle_ren", bus.ramREN, 0);

        // dcache drops its request mid-grant
        bus.dREN = 1; bus.daddr = 32'h104; bus.ramstate = BUSY;
        tick();
        @(negedge CLK); chk("drop_ren_on", bus.ramREN, 1);
        tick(); bus.dREN = 0; bus.ramstate = ACCESS;
        @(negedge CLK); chk("drop_ren_off", bus.ramREN, 0); chk("drop_dwait", bus.dwait, 1);
        tick();

        // RAM error during icache grant, then retry
        bus.iREN = 1; bus.iaddr = 32'h48; bus.ramstate = ERROR;
        tick();
        @(negedge CLK); chk("t5_iwait", bus.iwait, 1); chk("t5_err_pre", bus.arb_err, 0);
        chk("t5_ren", bus.ramREN, 1);
        tick(); bus.ramstate = ACCESS;
        @(negedge CLK); chk("t5_err_set", bus.arb_err, 1); chk("t5_idle_ren", bus.ramREN, 0);
        tick();
        @(negedge CLK); chk("t5_retry_iwait", bus.iwait, 0); chk("t5_err_sticky", bus.arb_err, 1);
        tick(); bus.iREN = 0;

        // async reset in the middle of a dcache write grant
        bus.dWEN = 1; bus.daddr = 32'h84; bus.dstore = 32'h55; bus.ramstate = BUSY;
        tick();
        @(negedge CLK); chk("t1_wen_pre", bus.ramWEN, 1);
        #2 nRST = 0;
        #1;
        chk("t1_wen", bus.ramWEN, 0); chk("t1_iwait", bus.iwait, 1); chk("t1_dwait", bus.dwait, 1);
        chk("t1_addr", bus.ramaddr, 0); chk("t1_err_clr", bus.arb_err, 0);
        bus.dWEN = 0;
        @(negedge CLK); #2 nRST = 1;

        // both caches hold requests: count grant order
        tick();
        bus.iREN = 1; bus.dREN = 1; bus.iaddr = 32'h50; bus.daddr = 32'h90; bus.ramstate = ACCESS;
        ntr = FAIR ? 5 : 20;
        for (int c = 0; c < 200 && seq.size() < ntr; c++) begin
            @(negedge CLK);
            if (!bus.dwait) seq.push_back(2);
            if (!bus.iwait) seq.push_back(1);
        end
        chk("t6_count", seq.size(), ntr);
        if (FAIR) begin
            for (int k = 0; k < seq.size() && k < 5; k++)
                chk("t6_fair_order", seq[k], (k < 4) ? 2 : 1);
        end else begin
            igr = 0;
            foreach (seq[k]) if (seq[k] == 1) igr++;
            chk("t6_no_i_grant", igr, 0);
        end
        tick(); bus.iREN = 0; bus.dREN = 0;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
